// File: rtl/reg_bank_2addr.sv
// Four-entry register bank with one-hot write decode, two bypassed read ports and a registered write trace.
// Optional build macro REG_ZERO_HARDWIRED_EN makes register 0 a constant zero.
module reg_bank_2addr #(
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              WriteEn,
    input  logic [1:0]        WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [1:0]        ReadAddr1,
    input  logic [1:0]        ReadAddr2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [3:0]        WriteOneHot
);

`ifdef REG_ZERO_HARDWIRED_EN
    localparam bit ZERO_HW = 1'b1;
`else
    localparam bit ZERO_HW = 1'b0;
`endif

    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [3:0]        write_onehot_q;
    logic [3:0]        write_onehot_d;
    logic [3:0]        store_en;

    // An unknown address matches no case item, so nothing is enabled and no bypass fires.
    always_comb begin
        write_onehot_d = 4'b0000;
        if (WriteEn) begin
            case (WriteAddr)
                2'd0:    write_onehot_d = 4'b0001;
                2'd1:    write_onehot_d = 4'b0010;
                2'd2:    write_onehot_d = 4'b0100;
                2'd3:    write_onehot_d = 4'b1000;
                default: write_onehot_d = 4'b0000;
            endcase
        end
    end

    always_comb begin
        store_en = write_onehot_d;
        if (ZERO_HW) begin
            store_en[0] = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = store_en[i] ? WriteData : regs_q[i];
        end
        if (ZERO_HW) begin
            regs_d[0] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            write_onehot_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            write_onehot_q <= write_onehot_d;
        end
    end

    // Bypass keys off the store enable, so a discarded write to a hardwired zero never leaks out.
    always_comb begin
        ReadData1 = store_en[ReadAddr1] ? WriteData : regs_q[ReadAddr1];
        ReadData2 = store_en[ReadAddr2] ? WriteData : regs_q[ReadAddr2];
        if (ZERO_HW && (ReadAddr1 == 2'd0)) begin
            ReadData1 = '0;
        end
        if (ZERO_HW && (ReadAddr2 == 2'd0)) begin
            ReadData2 = '0;
        end
    end

    assign WriteOneHot = write_onehot_q;

endmodule

// File: doc/reg_bank_2addr.md
# reg_bank_2addr

Four-entry register bank of the 4-bit unicycle datapath, addressed by the 2-bit destination/source fields. It is the consumer of the 2-bit write-register selection: it decodes the selected 2-bit destination into one-hot write enables and stores write-back data on the clock edge. It also serves two combinational read ports for the ALU operands. Write-to-read bypass lets a value written in a cycle be visible on the read ports in that same cycle.

## Interface
- DATA_W, 4, width of each register and of all data ports
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clock
- WriteEn  input  1  register-write strobe from control
- WriteAddr  input  2  destination register, already selected upstream
- WriteData  input  DATA_W  write-back value
- ReadAddr1  input  2  operand A register index
- ReadAddr2  input  2  operand B register index
- ReadData1  output  DATA_W  operand A value
- ReadData2  output  DATA_W  operand B value
- WriteOneHot  output  4  registered one-hot copy of the last accepted write enable, for debug/trace

## Operation
- Storage: regs[0..3], each DATA_W bits; WriteOneHot is 4 bits.
- Decode: WriteAddr maps to a one-hot enable: 0→0001, 1→0010, 2→0100, 3→1000. The enable is gated by WriteEn.
- Write: on a rising edge with reset=1 and WriteEn=1, regs[WriteAddr] <= WriteData and WriteOneHot <= decoded one-hot.
  - When WriteEn=0: no register changes and WriteOneHot <= 0000.
- Read: ReadDataN is combinational.
  - If WriteEn=1 and WriteAddr==ReadAddrN, ReadDataN = WriteData (bypass).
  - Otherwise ReadDataN = regs[ReadAddrN].
- Both read ports are independent. Equal ReadAddr1/ReadAddr2 return identical values.
- X/Z on WriteAddr with WriteEn=1: no register written; WriteOneHot <= 0000.
- Width rule: WriteData is stored unmodified, with no sign extension or truncation.

## Timing
- Reset: on a rising edge with reset=0, all regs <= 0 and WriteOneHot <= 0000.
  - Reset overrides a simultaneous WriteEn.
  - While held, ReadData1/2 = 0 unless bypass applies. Bypass stays combinational during reset, so the cycle after reset is released shows 0, not the bypassed value.
- Write latency: 1 edge to storage, 0 cycles to read ports via bypass.
- Reads reflect the stored value from the first cycle after the write edge.
- Back-to-back writes to the same address: the last edge wins. Each write is visible via bypass in its own cycle.
- Reset asserted mid-sequence discards all prior contents at that edge; no partial state survives.
- No handshakes; WriteEn is a single-cycle qualifier, and a multi-cycle assertion writes on every edge.

## Configuration
- REG_ZERO_HARDWIRED_EN defined:
  - register 0 is constant 0; writes to address 0 are discarded.
  - WriteOneHot still records 0001 for such a write, for trace.
  - reads of address 0 return 0 even when bypass would match.
- Undefined: register 0 is an ordinary writable register.

## Test plan
- Reset: reset=0 for 1 edge after writing regs[2]=4'hA -> all ReadData=0, WriteOneHot=0000; reading address 2 returns 0.
- Decode/write: WriteEn=1, WriteAddr=3, WriteData=4'h7, one edge -> WriteOneHot=1000; ReadAddr1=3 next cycle gives 4'h7; other registers still 0.
- Bypass: same cycle WriteEn=1, WriteAddr=1, WriteData=4'h5, ReadAddr1=ReadAddr2=1 -> both ReadData=4'h5 before the edge; after the edge with WriteEn=0, both still 4'h5.
- Write disabled: WriteEn=0, WriteAddr=2, WriteData=4'hF, edge -> regs[2] unchanged (0); WriteOneHot=0000.
- Reset priority: reset=0 and WriteEn=1, WriteAddr=1, WriteData=4'h9 on the same edge -> regs[1]=0 after the edge.
- Register zero: write 4'hC to address 0 -> with REG_ZERO_HARDWIRED_EN, ReadData1 (addr 0)=0 during and after, WriteOneHot=0001; without the macro, 4'hC is bypassed and then stored.
